uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
// - UART transmitter sitting directly downstream of the tx fifo; consumes its read side (empty/r_data/rd).
// - Pops one word whenever idle and fifo non-empty, serialises it as start/data(LSB first)/[parity]/stop.
// - Contains its own baud tick generator (16x oversampled bit timing); tx is the pad-level serial output.
// PARAMETERS
// - DATA_WIDTH  8   data bits per frame; matches fifo DATA_WIDTH
// - DVSR_WIDTH  11  width of baud divisor input
// - SB_TICK     16  stop-bit length in ticks (16=1, 24=1.5, 32=2 stop bits)
// PORTS
// - clk      in   1           system clock, all logic rising-edge
// - reset    in   1           asynchronous, active-high reset
// - dvsr     in   DVSR_WIDTH  baud divisor; tick period = dvsr+1 clocks, bit = 16 ticks
// - empty    in   1           fifo empty flag
// - r_data   in   DATA_WIDTH  fifo head word, valid combinationally while empty=0
// - rd       out  1           fifo pop strobe, one clock wide
// - tx       out  1           serial line, idle high
// - tx_busy  out  1           high from pop cycle+1 until end of stop bit
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, tx=1, rd=0, tx_busy=0, tick counter=0, shift reg=0.
// - Reset mid-frame: frame aborted, tx returns high at once; popped word is lost (no re-push).
// - All outputs registered except rd, which is a Moore decode of the POP cycle (glitch-free, 1 clk).
// - Tick gen: counter 0..dvsr_q, tick when counter==dvsr_q then wraps to 0; dvsr=0 -> tick every clock.
// - dvsr sampled into dvsr_q on the POP cycle; changes mid-frame take effect at the next frame only.
// - FSM: IDLE -> POP -> START -> DATA -> [PARITY] -> STOP -> IDLE/POP.
//   IDLE : tx=1; if empty=0 -> POP.
//   POP  : rd=1 for this clock; shift reg <= r_data; tick counter cleared; next START.
//   START: tx=0 for 16 ticks.
//   DATA : tx=shreg[0]; every 16 ticks shift right; after DATA_WIDTH bits -> PARITY or STOP.
//   STOP : tx=1 for SB_TICK ticks; then if empty=0 go straight to POP, else IDLE.
// - Latency: tx falls on the clock after rd=1; frame = (1+DATA_WIDTH[+1])*16 + SB_TICK ticks.
// - Back-to-back: POP cycle inserted between frames adds exactly one clock of idle-high line.
// - rd never asserted while empty=1; at most one rd per frame; empty rising during frame ignored.
// - Bit-counter width = clog2(DATA_WIDTH); tick-in-bit counter 5 bits (covers SB_TICK up to 32).
// CONFIGURATION
// - Macro UART_TX_PARITY_EN defined: PARITY state present, tx = even parity (XOR of data bits)
//   for 16 ticks between last data bit and stop; frame grows by 16 ticks.
// - Macro absent: no PARITY state, no parity logic; DATA goes directly to STOP.
// TESTING
// - dvsr=0, push 0x55, no parity -> one rd pulse; tx 0,1,0,1,0,1,0,1,0,1 each 16 clk; line busy 160 clk.
// - dvsr=3, push 0xA3 -> bit period 64 clk; tx after start = 1,1,0,0,0,1,0,1; tx_busy high 640 clk.
// - Push 0x01 and 0x80 together, dvsr=0 -> rd pulses exactly twice 161 clk apart; single idle clk between.
// - Fifo empty throughout, 1000 clk -> tx=1, rd=0, tx_busy=0 constant.
// - Assert reset 40 clk into frame of 0xFF -> tx=1, tx_busy=0 same cycle; after release and empty=1 no rd.
// - UART_TX_PARITY_EN, dvsr=0, push 0x07 -> parity bit 1 after data, frame 176 clk; 0x03 -> parity 0.
// - Change dvsr 0->3 mid-frame -> current frame keeps 16-clk bits; next frame uses 64-clk bits.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a tx fifo: pops a word when idle, sends start/data/[parity]/stop.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int DVSR_WIDTH = 11,
  parameter int SB_TICK    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int              BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [4:0]      LAST_TICK = 5'd15;
  localparam logic [4:0]      STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [DVSR_WIDTH-1:0] dvsr_q;
  logic [DVSR_WIDTH-1:0] cnt;
  logic [4:0]            s;
  logic [BW-1:0]         n;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nx;
  logic                  tick;

`ifdef UART_TX_PARITY_EN
  logic par;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  assign tick     = (cnt == dvsr_q);
  assign shreg_nx = shreg >> 1;
  // Pop strobe is a pure state decode so it is exactly one clean clock wide.
  assign rd       = (state == POP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      dvsr_q  <= '0;
      cnt     <= '0;
      s       <= '0;
      n       <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      // Baud counter runs only while a frame is in flight and restarts on every tick.
      if (state == IDLE || state == POP || tick)
        cnt <= '0;
      else
        cnt <= cnt + DVSR_WIDTH'(1);

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty)
            state <= POP;
        end
        POP: begin
          shreg   <= r_data;
          dvsr_q  <= dvsr;
          s       <= '0;
          n       <= '0;
          tx      <= 1'b0;
          tx_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
          par     <= even_parity(r_data);
`endif
          state   <= START;
        end
        START: begin
          if (tick) begin
            if (s == LAST_TICK) begin
              s     <= '0;
              tx    <= shreg[0];
              state <= DATA;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == LAST_TICK) begin
              s     <= '0;
              shreg <= shreg_nx;
              if (n == LAST_BIT) begin
                n     <= '0;
`ifdef UART_TX_PARITY_EN
                tx    <= par;
                state <= PARITY;
`else
                tx    <= 1'b1;
                state <= STOP;
`endif
              end else begin
                n  <= n + BW'(1);
                tx <= shreg_nx[0];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == LAST_TICK) begin
              s     <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == STOP_LAST) begin
              s       <= '0;
              tx_busy <= 1'b0;
              state   <= empty ? IDLE : POP;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: framing, baud timing, back-to-back pops, reset abort.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        empty;
  logic [7:0]  r_data;
  logic        rd;
  logic        tx;
  logic        tx_busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .DVSR_WIDTH(11), .SB_TICK(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .dvsr    (dvsr),
    .empty   (empty),
    .r_data  (r_data),
    .rd      (rd),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rd(input string tag);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rd && waited < 8);
    check(tag, rd, 1);
  endtask

  // One frame from idle; bits[k] is the k-th bit on the line (start first).
  task automatic frame(input logic [7:0] d, input logic p, input int dv, input int bp,
                       input int chg_at, input int chg_dv);
    logic [10:0] bits;
    int          nb;
    int          busy;
    int          rds;
    logic        txs [0:720];
    bits = PAR ? {1'b1, p, d, 1'b0} : {2'b01, d, 1'b0};
    nb   = PAR ? 11 : 10;
    if (dv >= 0) dvsr = 11'(dv);
    r_data = d;
    empty  = 1'b0;
    wait_rd($sformatf("rd_pulse_%02h", d));
    empty = 1'b1;
    check("tx_high_in_pop", tx, 1);
    busy = 0;
    rds  = 0;
    for (int i = 1; i <= nb*bp + 4; i++) begin
      @(negedge clk);
      if (i == chg_at) dvsr = 11'(chg_dv);
      txs[i] = tx;
      busy  += int'(tx_busy);
      rds   += int'(rd);
    end
    for (int k = 0; k < nb; k++) begin
      check($sformatf("%02h_bit%0d_first", d, k), txs[1 + k*bp], bits[k]);
      check($sformatf("%02h_bit%0d_last", d, k), txs[(k+1)*bp], bits[k]);
    end
    check($sformatf("%02h_idle_after", d), txs[nb*bp + 1], 1);
    check($sformatf("%02h_busy_clks", d), busy, nb*bp);
    check($sformatf("%02h_extra_rd", d), rds, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_tx, bad_rd, bad_busy, second, extra, g;
    logic b_tx   [0:400];
    logic b_busy [0:400];

    reset  = 1'b1;
    dvsr   = '0;
    empty  = 1'b1;
    r_data = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_rd", rd, 0);
    check("reset_busy", tx_busy, 0);
    reset = 1'b0;

    // Empty fifo: line stays quiet.
    bad_tx = 0; bad_rd = 0; bad_busy = 0;
    repeat (1000) begin
      @(negedge clk);
      bad_tx   += int'(tx !== 1'b1);
      bad_rd   += int'(rd !== 1'b0);
      bad_busy += int'(tx_busy !== 1'b0);
    end
    check("idle_tx_drops", bad_tx, 0);
    check("idle_rd_pulses", bad_rd, 0);
    check("idle_busy", bad_busy, 0);

    frame(8'h55, 1'b0, 0, 16, -1, 0);
    frame(8'hA3, 1'b0, 3, 64, -1, 0);

    // dvsr changes mid-frame: this frame keeps 16-clk bits, the next uses 64-clk bits.
    frame(8'h0E, 1'b1, 0, 16, 50, 3);
    frame(8'hC1, 1'b1, -1, 64, -1, 0);

`ifdef UART_TX_PARITY_EN
    frame(8'h07, 1'b1, 0, 16, -1, 0);
    frame(8'h03, 1'b0, 0, 16, -1, 0);
`endif

    // Two words queued: second pop follows stop bit with one idle-high clock.
    dvsr   = '0;
    r_data = 8'h01;
    empty  = 1'b0;
    wait_rd("b2b_first_rd");
    second = -1;
    extra  = 0;
    for (int i = 1; i <= 2*NB*16 + 5; i++) begin
      @(negedge clk);
      if (i == 1) r_data = 8'h80;
      b_tx[i]   = tx;
      b_busy[i] = tx_busy;
      if (rd) begin
        if (second < 0) second = i;
        else extra++;
        empty = 1'b1;
      end
    end
    check("b2b_rd_gap", second, NB*16 + 1);
    g = (second > 1 && second < 2*NB*16 - 200) ? second : NB*16 + 1;
    check("b2b_gap_tx_high", b_tx[g], 1);
    check("b2b_gap_not_busy", b_busy[g], 0);
    check("b2b_stop_tx", b_tx[g-1], 1);
    check("b2b_stop_busy", b_busy[g-1], 1);
    check("b2b_start2_tx", b_tx[g+1], 0);
    check("b2b_f1_bit0", b_tx[25], 1);
    check("b2b_f2_bit0", b_tx[g + 25], 0);
    check("b2b_f2_bit7", b_tx[g + 1 + 16*8 + 8], 1);
    check("b2b_extra_rd", extra, 0);

    // Reset in the middle of a frame aborts it immediately.
    r_data = 8'hFF;
    empty  = 1'b0;
    wait_rd("abort_rd");
    empty = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_start_low", tx, 0);
    repeat (32) @(negedge clk);
    check("abort_busy_before", tx_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_tx_now_high", tx, 1);
    check("abort_busy_now_low", tx_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    bad_tx = 0; bad_rd = 0;
    repeat (200) begin
      @(negedge clk);
      bad_tx += int'(tx !== 1'b1);
      bad_rd += int'(rd !== 1'b0);
    end
    check("post_reset_tx", bad_tx, 0);
    check("post_reset_rd", bad_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
